// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD Wishbone controller: FSM states,
// register word offsets and CTRL/STATUS bit positions.
package gcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam logic [7:0] OFF_OPA    = 8'h00;
  localparam logic [7:0] OFF_OPB    = 8'h04;
  localparam logic [7:0] OFF_CTRL   = 8'h08;
  localparam logic [7:0] OFF_STATUS = 8'h0C;
  localparam logic [7:0] OFF_RESULT = 8'h10;
  localparam logic [7:0] OFF_CYCLES = 8'h14;

  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;

  // Saturating increment for the 32-bit cycle counter
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/gcd_wb_regs.sv
// Wishbone slave front end: window decode, registered single-cycle ack,
// operand/control/status/result registers and the read mux.
module gcd_wb_regs
  import gcd_pkg::*;
#(
  parameter int          W         = 16,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_stb,
  input  logic         i_cyc,
  input  logic         i_we,
  input  logic [31:0]  i_adr,
  input  logic [31:0]  i_dat,
  output logic         o_ack,
  output logic [31:0]  o_dat,
  input  logic         i_busy,
  input  logic         i_capture,
  input  logic [W-1:0] i_result,
  input  logic [31:0]  i_cycles,
  output logic [W-1:0] o_opa,
  output logic [W-1:0] o_opb,
  output logic         o_start,
  output logic         o_irq_en,
  output logic         o_done
);

  logic         r_ack;
  logic [31:0]  r_dat;
  logic [W-1:0] r_opa;
  logic [W-1:0] r_opb;
  logic         r_irq_en;
  logic         r_done;
  logic         r_err;
  logic [W-1:0] r_result;

  logic         w_in_win;
  logic         w_acc;
  logic         w_wr;
  logic         w_rd;
  logic [7:0]   w_off;
  logic         w_start_req;
  logic         w_start_err;
  logic         w_clr_done;
  logic         w_clr_err;
  logic [31:0]  w_rdata;
  logic         w_unused;

  // Only full words are used; upper data bits beyond W are don't-care.
  assign w_unused = ^i_dat;

  // An access is taken only while ack is low, so back-to-back strobes
  // are acknowledged every other cycle.
  assign w_in_win = (i_adr[31:8] == BASE_ADDR[31:8]);
  assign w_acc    = i_stb & i_cyc & w_in_win & ~r_ack;
  assign w_wr     = w_acc & i_we;
  assign w_rd     = w_acc & ~i_we;
  assign w_off    = i_adr[7:0];

  // START is honoured only when idle; a START while busy flags ERR instead.
  assign w_start_req = w_wr & (w_off == OFF_CTRL) & i_dat[CTRL_START];
  assign o_start     = w_start_req & ~i_busy;
  assign w_start_err = w_start_req & i_busy;
  assign w_clr_done  = w_wr & (w_off == OFF_STATUS) & i_dat[STAT_DONE];
  assign w_clr_err   = w_wr & (w_off == OFF_STATUS) & i_dat[STAT_ERR];

  // Read mux: unmapped in-window offsets read as zero
  always_comb begin
    w_rdata = '0;
    case (w_off)
      OFF_OPA:    w_rdata = 32'(r_opa);
      OFF_OPB:    w_rdata = 32'(r_opb);
      OFF_CTRL:   w_rdata = {30'd0, r_irq_en, 1'b0};
      OFF_STATUS: w_rdata = {29'd0, r_err, r_done, i_busy};
      OFF_RESULT: w_rdata = 32'(r_result);
      OFF_CYCLES: w_rdata = i_cycles;
      default:    w_rdata = '0;
    endcase
  end

  // Bus handshake: ack and read data land on the same edge as the access
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_acc;
      r_dat <= w_rd ? w_rdata : '0;
    end
  end

  // Writable registers and result capture
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_opa    <= '0;
      r_opb    <= '0;
      r_irq_en <= 1'b0;
      r_result <= '0;
    end else begin
      if (w_wr && (w_off == OFF_OPA))  r_opa    <= i_dat[W-1:0];
      if (w_wr && (w_off == OFF_OPB))  r_opb    <= i_dat[W-1:0];
      if (w_wr && (w_off == OFF_CTRL)) r_irq_en <= i_dat[CTRL_IRQ_EN];
      if (i_capture)                   r_result <= i_result;
    end
  end

  // Sticky status flags: a set on the same edge as a W1C clear wins
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      if (i_capture)                    r_done <= 1'b1;
      else if (o_start || w_clr_done)   r_done <= 1'b0;
      if (w_start_err)                  r_err  <= 1'b1;
      else if (w_clr_err)               r_err  <= 1'b0;
    end
  end

  assign o_ack    = r_ack;
  assign o_dat    = r_dat;
  assign o_opa    = r_opa;
  assign o_opb    = r_opb;
  assign o_irq_en = r_irq_en;
  assign o_done   = r_done;

endmodule

// File: rtl/gcd_wb_ctrl.sv
// GCD controller top: sequences one val/rdy request to the external GCD
// unit per START, captures the response and counts elapsed cycles.
module gcd_wb_ctrl
  import gcd_pkg::*;
#(
  parameter int          W         = 16,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  input  logic           wbs_stb_i,
  input  logic           wbs_cyc_i,
  input  logic           wbs_we_i,
  input  logic [3:0]     wbs_sel_i,
  input  logic [31:0]    wbs_adr_i,
  input  logic [31:0]    wbs_dat_i,
  output logic           wbs_ack_o,
  output logic [31:0]    wbs_dat_o,
  output logic           req_val,
  input  logic           req_rdy,
  output logic [2*W-1:0] req_msg,
  input  logic           resp_val,
  output logic           resp_rdy,
  input  logic [W-1:0]   resp_msg,
  output logic [2:0]     user_irq
);

  state_t         r_state;
  state_t         w_next;
  logic [2*W-1:0] r_msg;
  logic [31:0]    r_cycles;

  logic           w_busy;
  logic           w_start;
  logic           w_capture;
  logic [W-1:0]   w_opa;
  logic [W-1:0]   w_opb;
  logic           w_irq_en;
  logic           w_done;
  logic           w_unused;

  // Byte selects carry no meaning: every access is a full word.
  assign w_unused = ^wbs_sel_i;

  assign w_busy    = (r_state != ST_IDLE);
  assign w_capture = (r_state == ST_WAIT) & resp_val;

  gcd_wb_regs #(
    .W         (W),
    .BASE_ADDR (BASE_ADDR)
  ) u_regs (
    .i_clk     (wb_clk_i),
    .i_rst     (wb_rst_i),
    .i_stb     (wbs_stb_i),
    .i_cyc     (wbs_cyc_i),
    .i_we      (wbs_we_i),
    .i_adr     (wbs_adr_i),
    .i_dat     (wbs_dat_i),
    .o_ack     (wbs_ack_o),
    .o_dat     (wbs_dat_o),
    .i_busy    (w_busy),
    .i_capture (w_capture),
    .i_result  (resp_msg),
    .i_cycles  (r_cycles),
    .o_opa     (w_opa),
    .o_opb     (w_opb),
    .o_start   (w_start),
    .o_irq_en  (w_irq_en),
    .o_done    (w_done)
  );

  // FSM state register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // FSM next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_start)            w_next = ST_SEND;
      ST_SEND: if (req_val && req_rdy) w_next = ST_WAIT;
      ST_WAIT: if (resp_val)           w_next = ST_IDLE;
      default:                         w_next = ST_IDLE;
    endcase
  end

  // FSM outputs: request valid in SEND, response ready in WAIT
  always_comb begin
    req_val  = 1'b0;
    resp_rdy = 1'b0;
    case (r_state)
      ST_SEND: req_val  = 1'b1;
      ST_WAIT: resp_rdy = 1'b1;
      default: ;
    endcase
  end

  // Operand snapshot at START keeps the in-flight request immune to later
  // OPA/OPB writes; the counter runs for every non-idle cycle.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_msg    <= '0;
      r_cycles <= '0;
    end else if (w_start) begin
      r_msg    <= {w_opa, w_opb};
      r_cycles <= '0;
    end else if (w_busy) begin
      r_cycles <= sat_inc32(r_cycles);
    end
  end

  assign req_msg  = r_msg;
  assign user_irq = {2'b00, w_done & w_irq_en};

endmodule
